// File: rtl/addsub_pkg.sv
// Shared definitions for the mantissa add/subtract pipeline.
//   OP_ADD / OP_SUB   : encoding of the per-transaction op bit
//   addsub_width_ok() : elaboration-time check that the carry chain splits
//                       evenly into pipeline stages
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic bit addsub_width_ok(input int width, input int stages);
    return (stages < 1) ? 1'b0 : ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// One carry-chain chunk: combinational CHUNK-bit add of a and (b ^ op)
// with carry-in and carry-out. Subtraction comes from op=1 plus cin=1 on
// the lowest chunk.
//   a, b  : operand chunks
//   op    : 0 = add, 1 = subtract (inverts b)
//   cin   : carry into bit 0 of the chunk
//   sum   : chunk result
//   cout  : carry out of the chunk MSB
module addsub_slice #(
  parameter int CHUNK = 12
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             op,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK-1:0] b_x;

  assign b_x = b ^ {CHUNK{op}};
  assign {cout, sum} = {1'b0, a} + {1'b0, b_x} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/mantissa_addsub_pipe.sv
// Pipelined two's-complement adder/subtractor for the mantissa datapath.
// The carry chain is split into STAGES registered chunks of WIDTH/STAGES
// bits; operands, op and partial sums travel with each transaction so the
// last stage presents an aligned result. A single stall signal freezes the
// whole pipe when the output is held by downstream.
//
// Optional feature macro: MAG_CORRECT_EN adds one registered stage that
// turns a borrowed difference into its magnitude and flags it on out_neg.
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : input handshake
//   in_a, in_b, in_op      : operands and op (0 add, 1 subtract)
//   out_valid/out_ready    : output handshake
//   out_result, out_cout   : result and carry out of the MSB
//   out_neg                : result was negated to a magnitude
module mantissa_addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 24,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_neg
);

  localparam int CHUNK = WIDTH / STAGES;

  if (!addsub_width_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("mantissa_addsub_pipe: STAGES must be >= 1 and divide WIDTH");
  end

  // Stage inputs (combinational) and stage output registers.
  logic [WIDTH-1:0] a_i   [0:STAGES-1];
  logic [WIDTH-1:0] b_i   [0:STAGES-1];
  logic [WIDTH-1:0] sum_i [0:STAGES-1];
  logic [WIDTH-1:0] sum_n [0:STAGES-1];
  logic [CHUNK-1:0] s_chunk [0:STAGES-1];
  logic             op_i  [0:STAGES-1];
  logic             c_i   [0:STAGES-1];
  logic             v_i   [0:STAGES-1];
  logic             co_w  [0:STAGES-1];

  logic [WIDTH-1:0] a_r   [0:STAGES-1];
  logic [WIDTH-1:0] b_r   [0:STAGES-1];
  logic [WIDTH-1:0] sum_r [0:STAGES-1];
  logic             op_r  [0:STAGES-1];
  logic             co_r  [0:STAGES-1];
  logic             v_r   [0:STAGES-1];

  logic stall;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Bit positions this stage owns within the full-width partial sum.
    localparam logic [WIDTH-1:0] MASK =
      ((WIDTH'(1) << CHUNK) - WIDTH'(1)) << (k * CHUNK);

    if (k == 0) begin : g_head
      assign a_i[k]   = in_a;
      assign b_i[k]   = in_b;
      assign op_i[k]  = in_op;
      assign c_i[k]   = in_op;
      assign v_i[k]   = in_valid;
      assign sum_i[k] = '0;
    end else begin : g_body
      assign a_i[k]   = a_r[k-1];
      assign b_i[k]   = b_r[k-1];
      assign op_i[k]  = op_r[k-1];
      assign c_i[k]   = co_r[k-1];
      assign v_i[k]   = v_r[k-1];
      assign sum_i[k] = sum_r[k-1];
    end

    addsub_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (a_i[k][k*CHUNK +: CHUNK]),
      .b    (b_i[k][k*CHUNK +: CHUNK]),
      .op   (op_i[k]),
      .cin  (c_i[k]),
      .sum  (s_chunk[k]),
      .cout (co_w[k])
    );

    assign sum_n[k] = (sum_i[k] & ~MASK) | (WIDTH'(s_chunk[k]) << (k * CHUNK));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_r[k]   <= '0;
        b_r[k]   <= '0;
        sum_r[k] <= '0;
        op_r[k]  <= 1'b0;
        co_r[k]  <= 1'b0;
        v_r[k]   <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        a_r[k]   <= a_i[k];
        b_r[k]   <= b_i[k];
        sum_r[k] <= sum_n[k];
        op_r[k]  <= op_i[k];
        co_r[k]  <= co_w[k];
        v_r[k]   <= v_i[k];
      end
    end
  end

`ifdef MAG_CORRECT_EN
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic [WIDTH-1:0] res_q;
  logic             cout_q;
  logic             neg_q;
  logic             valid_q;

  // A subtract with no carry out borrowed: present |A-B| instead of the
  // wrapped two's-complement value.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      cout_q  <= 1'b0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q <= v_r[STAGES-1];
      cout_q  <= co_r[STAGES-1];
      if ((op_r[STAGES-1] == OP_SUB) && !co_r[STAGES-1]) begin
        res_q <= ~sum_r[STAGES-1] + ONE_W;
        neg_q <= 1'b1;
      end else begin
        res_q <= sum_r[STAGES-1];
        neg_q <= 1'b0;
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_result = res_q;
  assign out_cout   = cout_q;
  assign out_neg    = neg_q;
`else
  assign out_valid  = v_r[STAGES-1];
  assign out_result = sum_r[STAGES-1];
  assign out_cout   = co_r[STAGES-1];
  assign out_neg    = 1'b0;
`endif

endmodule

// File: tb/tb_mantissa_addsub_pipe.sv
module tb_mantissa_addsub_pipe;

`ifdef MAG_CORRECT_EN
  localparam int LAT = 3;
  localparam bit MAG = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit MAG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_a;
  logic [23:0] in_b;
  logic        in_op;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_result;
  logic        out_cout;
  logic        out_neg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mantissa_addsub_pipe #(.WIDTH(24), .STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout),
    .out_neg    (out_neg)
  );

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic        op;
    logic [23:0] res;   // raw result
    logic        cout;
    logic [23:0] mres;  // result with magnitude correction
    logic        neg;   // out_neg with magnitude correction
  } vec_t;

  vec_t vecs [10];

  logic [23:0] st_a  [8];
  logic [23:0] st_b  [8];
  logic        st_op [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: subtraction as a - b + 2^24, carry = bit 24.
  function automatic logic [25:0] model(input logic [23:0] a, input logic [23:0] b,
                                        input logic op);
    logic [24:0] t;
    logic [23:0] r;
    logic        n;
    if (op) t = {1'b0, a} + 25'h1000000 - {1'b0, b};
    else    t = {1'b0, a} + {1'b0, b};
    r = t[23:0];
    n = 1'b0;
    if (MAG && op && !t[24]) begin
      r = b - a;
      n = 1'b1;
    end
    return {n, t[24], r};
  endfunction

  task automatic run_stream(input bit with_stall, input string tag);
    int          sent;
    int          rcvd;
    int          cyc;
    int          first_out;
    int          last_out;
    bit          prev_stall;
    logic [25:0] prev;
    logic [25:0] exp;
    logic [25:0] q [$];
    sent = 0; rcvd = 0; cyc = 0; first_out = -1; last_out = -1;
    prev_stall = 1'b0; prev = '0;
    while (rcvd < 8 && cyc < 100) begin
      in_valid = (sent < 8);
      if (sent < 8) begin
        in_a  = st_a[sent];
        in_b  = st_b[sent];
        in_op = st_op[sent];
      end
      out_ready = with_stall ? !(cyc >= 4 && cyc < 8) : 1'b1;
      #1;
      chk({tag, "_in_ready"}, 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_stall_stable"}, 32'({out_neg, out_cout, out_result}), 32'(prev));
      end
      prev_stall = out_valid && !out_ready;
      prev = {out_neg, out_cout, out_result};
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk({tag, "_extra_result"}, 32'd1, 32'd0);
        end else begin
          exp = q.pop_front();
          chk({tag, "_data"}, 32'({out_neg, out_cout, out_result}), 32'(exp));
        end
        rcvd++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_a, in_b, in_op));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_count"}, 32'(rcvd), 32'd8);
    chk({tag, "_leftover"}, 32'(q.size()), 32'd0);
    chk({tag, "_first_latency"}, 32'(first_out), 32'(LAT));
    chk({tag, "_span"}, 32'(last_out - first_out), with_stall ? 32'd11 : 32'd7);
  endtask

  initial begin
    int cyc;
    int seen;
    logic [23:0] er;
    logic        en;

    vecs[0] = '{24'h800000, 24'h400000, 1'b1, 24'h400000, 1'b1, 24'h400000, 1'b0};
    vecs[1] = '{24'h400000, 24'h800000, 1'b1, 24'hC00000, 1'b0, 24'h400000, 1'b1};
    vecs[2] = '{24'h000FFF, 24'h000001, 1'b0, 24'h001000, 1'b0, 24'h001000, 1'b0};
    vecs[3] = '{24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1, 24'h000000, 1'b0};
    vecs[4] = '{24'h123456, 24'h654321, 1'b0, 24'h777777, 1'b0, 24'h777777, 1'b0};
    vecs[5] = '{24'h000000, 24'h000001, 1'b1, 24'hFFFFFF, 1'b0, 24'h000001, 1'b1};
    vecs[6] = '{24'h000FFF, 24'h000FFF, 1'b1, 24'h000000, 1'b1, 24'h000000, 1'b0};
    vecs[7] = '{24'h800000, 24'h800000, 1'b0, 24'h000000, 1'b1, 24'h000000, 1'b0};
    vecs[8] = '{24'h001000, 24'h000001, 1'b1, 24'h000FFF, 1'b1, 24'h000FFF, 1'b0};
    vecs[9] = '{24'hABCDEF, 24'h111111, 1'b0, 24'hBCDF00, 1'b0, 24'hBCDF00, 1'b0};

    st_a  = '{24'h100000, 24'h000FFF, 24'h00ABCD, 24'hFFF000, 24'h555555, 24'h000001, 24'h7FFFFF, 24'hC00000};
    st_b  = '{24'h0F0000, 24'h000001, 24'h0ABCDE, 24'h001000, 24'hAAAAAA, 24'h000002, 24'h7FFFFF, 24'h400001};
    st_op = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(out_result), 32'd0);
    chk("rst_cout", 32'(out_cout), 32'd0);
    chk("rst_neg", 32'(out_neg), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single transactions: latency and value.
    for (int i = 0; i < 10; i++) begin
      er = MAG ? vecs[i].mres : vecs[i].res;
      en = MAG ? vecs[i].neg : 1'b0;
      in_a = vecs[i].a; in_b = vecs[i].b; in_op = vecs[i].op; in_valid = 1'b1;
      #1;
      chk("vec_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk($sformatf("vec%0d_latency", i), 32'(cyc), 32'(LAT));
      chk($sformatf("vec%0d_result", i), 32'(out_result), 32'(er));
      chk($sformatf("vec%0d_cout", i), 32'(out_cout), 32'(vecs[i].cout));
      chk($sformatf("vec%0d_neg", i), 32'(out_neg), 32'(en));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_single", i), 32'(out_valid), 32'd0);
    end

    run_stream(1'b0, "stream");
    repeat (4) @(posedge clk);
    #1;
    run_stream(1'b1, "stall");
    repeat (4) @(posedge clk);
    #1;

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    in_a = 24'h300000; in_b = 24'h100000; in_op = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 24'h000123; in_b = 24'h000456; in_op = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("rst_flight_valid", 32'(out_valid), 32'd0);
    chk("rst_flight_result", 32'(out_result), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("rst_flight_never_out", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
